// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronised lock, then releases sys_rst_n.
// Optional retry limit with a terminal FAIL state is enabled by defining PLL_RETRY_LIMIT_EN.
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lock_pipe;
  logic             locked_s;

  assign locked_s = lock_pipe[1];
  assign state    = cur;

`ifdef PLL_RETRY_LIMIT_EN
  localparam int RTRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;
  localparam logic [RTRY_W-1:0] RTRY_LAST = RTRY_W'(MAX_RETRIES - 1);

  logic [RTRY_W-1:0] retry;
  logic              timeout;
`endif

  always_comb begin
    nxt = cur;
`ifdef PLL_RETRY_LIMIT_EN
    timeout = 1'b0;
`endif
    case (cur)
      S_RESET:
        if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (locked_s) nxt = S_STABLE;
        else if (cnt == TO_LAST) begin
`ifdef PLL_RETRY_LIMIT_EN
          timeout = 1'b1;
          nxt     = (retry == RTRY_LAST) ? S_FAIL : S_RESET;
`else
          nxt = S_RESET;
`endif
        end
      // a lock glitch only restarts the wait, the PLL is not reset again
      S_STABLE:
        if (!locked_s) nxt = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) nxt = S_RUN;
      S_RUN:
        if (!locked_s) nxt = S_RESET;
`ifdef PLL_RETRY_LIMIT_EN
      S_FAIL:
        nxt = S_FAIL;
`endif
      default:
        nxt = S_RESET;
    endcase
    if (soft_reset) nxt = S_RESET;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= S_RESET;
      cnt           <= '0;
      lock_pipe     <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      lock_pipe <= {lock_pipe[0], pll_locked};
      cur       <= nxt;
      // soft_reset restarts a full pll_rst pulse even when already in RESET
      if (nxt != cur || soft_reset) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      pll_rst   <= (nxt == S_RESET) || (nxt == S_FAIL);
      sys_rst_n <= (nxt == S_RUN);
      if (cur == S_RUN && !locked_s && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  // a timeout coinciding with soft_reset is dropped so retry never exceeds RTRY_LAST
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry <= '0;
      fail  <= 1'b0;
    end else begin
      fail <= (nxt == S_FAIL);
      if (cur == S_FAIL && soft_reset) retry <= '0;
      else if (nxt == S_RUN)           retry <= '0;
      else if (timeout && !soft_reset) retry <= retry + 1'b1;
    end
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: stimulus queues hand-timed output events, a monitor
// pops one each time the observed output tuple changes and checks values and cycle.
module tb_pll_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst, sys_rst_n, fail;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  pll_reset_ctrl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(20)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .state(state),
    .lock_loss_cnt(lock_loss_cnt), .fail(fail)
  );

  always #10 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         id;
    logic [2:0] st;
    logic       prst;
    logic       srst;
    logic [7:0] llc;
    logic       fl;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_ev  = 0;

  task automatic expect_ev(input int off, input logic [2:0] st, input logic prst,
                           input logic srst, input logic [7:0] llc, input logic fl);
    ev_t e;
    e.cyc  = (off < 0) ? -1 : cyc + off;
    e.id   = n_ev;
    e.st   = st;
    e.prst = prst;
    e.srst = srst;
    e.llc  = llc;
    e.fl   = fl;
    n_ev++;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  // monitor
  initial begin
    logic [13:0] obs, prev, want;
    bit          have_prev;
    ev_t         e;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge refclk);
      obs = {state, pll_rst, sys_rst_n, lock_loss_cnt, fail};
      if (!have_prev || obs !== prev) begin
        have_prev = 1'b1;
        prev      = obs;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d got st=%0d prst=%0b srst=%0b llc=%0d fail=%0b, no event queued",
                   cyc, state, pll_rst, sys_rst_n, lock_loss_cnt, fail);
        end else begin
          e    = q.pop_front();
          want = {e.st, e.prst, e.srst, e.llc, e.fl};
          if ((e.cyc >= 0 && e.cyc != cyc) || obs !== want) begin
            n_bad++;
            $display("FAIL event%0d got cyc=%0d st=%0d prst=%0b srst=%0b llc=%0d fail=%0b, want cyc=%0d st=%0d prst=%0b srst=%0b llc=%0d fail=%0b",
                     e.id, cyc, state, pll_rst, sys_rst_n, lock_loss_cnt, fail,
                     e.cyc, e.st, e.prst, e.srst, e.llc, e.fl);
          end
        end
      end else if (q.size() > 0 && q[0].cyc >= 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL event%0d_missing got no change by cyc=%0d, want st=%0d prst=%0b srst=%0b llc=%0d fail=%0b at cyc=%0d",
                 e.id, cyc, e.st, e.prst, e.srst, e.llc, e.fl, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got time limit reached, want $finish before it");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int e;
    #1 rst_n = 1'b0;
    expect_ev(-1, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    tick(3);

    // power-up with lock present
    pll_locked = 1'b1;
    rst_n      = 1'b1;
    expect_ev(4,  3'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_ev(5,  3'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_ev(13, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0);
    tick(16);

    // lock lost in RUN and never returns: timeouts
    pll_locked = 1'b0;
    expect_ev(3,  3'd0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_ev(7,  3'd1, 1'b0, 1'b0, 8'd1, 1'b0);
    expect_ev(27, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_ev(31, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0);
`ifdef PLL_RETRY_LIMIT_EN
    expect_ev(51, 3'd4, 1'b1, 1'b0, 8'd1, 1'b1);
`else
    expect_ev(51, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_ev(55, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0);
`endif
    tick(60);

    soft_reset = 1'b1;
    expect_ev(1, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_ev(5, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0);
    tick(1);
    soft_reset = 1'b0;
    tick(7);

    // lock arrives, then a one-cycle glitch in the 5th STABLE cycle
    pll_locked = 1'b1;
    expect_ev(3,  3'd2, 1'b0, 1'b0, 8'd1, 1'b0);
    expect_ev(8,  3'd1, 1'b0, 1'b0, 8'd1, 1'b0);
    expect_ev(9,  3'd2, 1'b0, 1'b0, 8'd1, 1'b0);
    expect_ev(17, 3'd3, 1'b0, 1'b1, 8'd1, 1'b0);
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(14);

    // soft_reset coinciding with a lock loss in RUN
    pll_locked = 1'b0;
    expect_ev(3,  3'd0, 1'b1, 1'b0, 8'd2, 1'b0);
    expect_ev(7,  3'd1, 1'b0, 1'b0, 8'd2, 1'b0);
    expect_ev(8,  3'd2, 1'b0, 1'b0, 8'd2, 1'b0);
    expect_ev(16, 3'd3, 1'b0, 1'b1, 8'd2, 1'b0);
    tick(2);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    pll_locked = 1'b1;
    tick(17);

    // asynchronous reset while in RUN
    rst_n = 1'b0;
    expect_ev(0, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    expect_ev(4,  3'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_ev(5,  3'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    expect_ev(13, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0);
    tick(16);

    // 256 lock losses: counter saturates at 255
    for (int i = 0; i < 256; i++) begin
      e = (i + 1 > 255) ? 255 : i + 1;
      pll_locked = 1'b0;
      expect_ev(3,  3'd0, 1'b1, 1'b0, 8'(e), 1'b0);
      expect_ev(7,  3'd1, 1'b0, 1'b0, 8'(e), 1'b0);
      expect_ev(8,  3'd2, 1'b0, 1'b0, 8'(e), 1'b0);
      expect_ev(16, 3'd3, 1'b0, 1'b1, 8'(e), 1'b0);
      tick(3);
      pll_locked = 1'b1;
      tick(14);
    end
    tick(5);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got %0d left, want 0", q.size());
    end
    n_cmp++;
    if (lock_loss_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL lock_loss_sat got %0d, want 255", lock_loss_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
